mips_multicycle_control: RTL and testbench

//  Main control unit for the multicycle MIPS datapath. Consumes the 6-bit opcode
//  (IR[31:26]) from the datapath and drives every datapath control line, one FSM

---
 rtl/mips_ctrl_pkg.sv | 56 +++++
 rtl/mips_ctrl_outdec.sv | 56 +++++
 rtl/mips_multicycle_control.sv | 81 ++++++++
 tb/tb_mips_multicycle_control.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, state encodings and control-field constants for the multicycle MIPS control unit
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12,
    S_HALT   = 4'd13
  } state_t;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMM2  = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
  } ctrl_t;
  function automatic logic is_final(input logic [3:0] s);
    return s inside {S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_IWB};
  endfunction
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction
endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: Moore decode of the state register into datapath control lines
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM2;
      S_MEMADR, S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      S_IWB: ctrl.reg_write = 1'b1;
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS main control FSM with retired-instruction counter
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int COUNT_W      = 32,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [3:0]         state,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);
  logic [3:0] st;
  logic [3:0] nxt;
  ctrl_t      ctrl;
  logic       mem_op;
  assign mem_op = opcode == OP_LW || opcode == OP_SW;
  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = opcode == OP_RTYPE ? S_REXEC :
                      mem_op             ? S_MEMADR :
                      opcode == OP_BEQ   ? S_BRANCH :
                      opcode == OP_J     ? S_JUMP :
                      opcode == OP_ADDI  ? S_IEXEC :
                      ILLEGAL_HALT       ? S_HALT : S_FETCH;
      S_MEMADR: nxt = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = S_MEMWB;
      S_REXEC:  nxt = S_RWB;
      S_IEXEC:  nxt = S_IWB;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end
  // every final state returns to FETCH unconditionally, so being in one means an instruction retires
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st          <= S_RESET;
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      st          <= nxt;
      instr_count <= instr_count + COUNT_W'(is_final(st));
      illegal_op  <= st == S_DECODE && !is_legal(opcode);
    end
  end
  mips_ctrl_outdec u_outdec (
    .state(st),
    .ctrl (ctrl)
  );
  assign state       = st;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IorD        = ctrl.iord;
  assign RegWrite    = ctrl.reg_write;
  assign IRWrite     = ctrl.ir_write;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: vector table plus scoreboard over three variants
// (default, ILLEGAL_HALT=1, COUNT_W=4) sharing clock, reset and opcode
module tb_mips_multicycle_control;
  localparam logic [3:0] T_RESET = 4'd0, T_FETCH = 4'd1, T_DECODE = 4'd2, T_MEMADR = 4'd3,
    T_MEMRD = 4'd4, T_MEMWB = 4'd5, T_MEMWR = 4'd6, T_REXEC = 4'd7, T_RWB = 4'd8,
    T_BRANCH = 4'd9, T_JUMP = 4'd10, T_IEXEC = 4'd11, T_IWB = 4'd12, T_HALT = 4'd13;
  // {ALUOp,ALUSrcA,ALUSrcB,PCSource,RegDst,MemtoReg,MemRead,MemWrite,IorD,RegWrite,IRWrite,PCWrite,PCWriteCond}
  localparam logic [16:0] C_NONE   = 17'b00_0_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_FETCH  = 17'b00_0_01_00_0_0_1_0_0_0_1_1_0;
  localparam logic [16:0] C_DECODE = 17'b00_0_11_00_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_MEMADR = 17'b00_1_10_00_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_MEMRD  = 17'b00_0_00_00_0_0_1_0_1_0_0_0_0;
  localparam logic [16:0] C_MEMWB  = 17'b00_0_00_00_0_1_0_0_0_1_0_0_0;
  localparam logic [16:0] C_MEMWR  = 17'b00_0_00_00_0_0_0_1_1_0_0_0_0;
  localparam logic [16:0] C_REXEC  = 17'b10_1_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_RWB    = 17'b00_0_00_00_1_0_0_0_0_1_0_0_0;
  localparam logic [16:0] C_BRANCH = 17'b01_1_00_01_0_0_0_0_0_0_0_0_1;
  localparam logic [16:0] C_JUMP   = 17'b00_0_00_10_0_0_0_0_0_0_0_1_0;
  localparam logic [16:0] C_IEXEC  = 17'b00_1_10_00_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_IWB    = 17'b00_0_00_00_0_0_0_0_0_1_0_0_0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic [3:0]  st [3];
  logic [16:0] ctrl [3];
  logic        ill [3];
  logic [31:0] count [3];
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int CW = g == 2 ? 4 : 32;
    logic [1:0]    alu_op, src_b, pc_src;
    logic          src_a, reg_dst, mem_to_reg, mem_read, mem_write, iord, reg_write, ir_write, pc_write, pc_wc;
    logic [CW-1:0] cnt;
    mips_multicycle_control #(.COUNT_W(CW), .ILLEGAL_HALT(g == 1)) dut (
      .clock(clock), .reset(reset), .opcode(opcode),
      .ALUOp(alu_op), .ALUSrcA(src_a), .ALUSrcB(src_b), .PCSource(pc_src),
      .RegDst(reg_dst), .MemtoReg(mem_to_reg), .MemRead(mem_read), .MemWrite(mem_write),
      .IorD(iord), .RegWrite(reg_write), .IRWrite(ir_write), .PCWrite(pc_write),
      .PCWriteCond(pc_wc), .state(st[g]), .illegal_op(ill[g]), .instr_count(cnt)
    );
    assign ctrl[g]  = {alu_op, src_a, src_b, pc_src, reg_dst, mem_to_reg, mem_read, mem_write,
                       iord, reg_write, ir_write, pc_write, pc_wc};
    assign count[g] = 32'(cnt);
  end

  typedef struct packed {
    logic [5:0]  op;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic        ill;
    logic [31:0] cnt;
  } vec_t;
  typedef struct packed {
    logic [1:0]  d;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb [$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        halted = 1'b0;
  logic [31:0] hcnt = 0;
  logic [31:0] mcnt = 0;
  vec_t        tbl [30];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("state", int'(e.d), 32'(st[e.d]), 32'(e.st));
    chk("ctrl", int'(e.d), 32'(ctrl[e.d]), 32'(e.ctrl));
    chk("illegal_op", int'(e.d), 32'(ill[e.d]), 32'(e.ill));
    chk("instr_count", int'(e.d), count[e.d], e.cnt);
  endtask

  // drive one cycle of main-variant expectations; the halt and narrow-counter variants derive theirs
  task automatic go(input logic [5:0] op, input logic [3:0] s, input logic [16:0] c, input logic il,
                    input logic [31:0] n);
    opcode = op;
    sb.push_back('{2'd0, s, c, il, n});
    if (!halted && il) begin
      halted = 1'b1;
      hcnt   = n;
      sb.push_back('{2'd1, T_HALT, C_NONE, 1'b1, n});
    end else
      sb.push_back(halted ? '{2'd1, T_HALT, C_NONE, 1'b0, hcnt} : '{2'd1, s, c, il, n});
    sb.push_back('{2'd2, s, c, il, n & 32'hf});
    @(posedge clock);
    #1;
    while (sb.size() > 0) check_all(sb.pop_front());
  endtask

  task automatic r_type();
    go(6'h00, T_DECODE, C_DECODE, 1'b0, mcnt);
    go(6'h00, T_REXEC, C_REXEC, 1'b0, mcnt);
    go(6'h00, T_RWB, C_RWB, 1'b0, mcnt);
    mcnt++;
    go(6'h00, T_FETCH, C_FETCH, 1'b0, mcnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl = '{
      '{6'h00, T_FETCH,  C_FETCH,  1'b0, 32'd0},
      '{6'h00, T_DECODE, C_DECODE, 1'b0, 32'd0},
      '{6'h00, T_REXEC,  C_REXEC,  1'b0, 32'd0},
      '{6'h00, T_RWB,    C_RWB,    1'b0, 32'd0},
      '{6'h00, T_FETCH,  C_FETCH,  1'b0, 32'd1},
      '{6'h23, T_DECODE, C_DECODE, 1'b0, 32'd1},
      '{6'h23, T_MEMADR, C_MEMADR, 1'b0, 32'd1},
      '{6'h23, T_MEMRD,  C_MEMRD,  1'b0, 32'd1},
      '{6'h23, T_MEMWB,  C_MEMWB,  1'b0, 32'd1},
      '{6'h23, T_FETCH,  C_FETCH,  1'b0, 32'd2},
      '{6'h3f, T_DECODE, C_DECODE, 1'b0, 32'd2},
      '{6'h2b, T_MEMADR, C_MEMADR, 1'b0, 32'd2},
      '{6'h2b, T_MEMWR,  C_MEMWR,  1'b0, 32'd2},
      '{6'h23, T_FETCH,  C_FETCH,  1'b0, 32'd3},
      '{6'h04, T_DECODE, C_DECODE, 1'b0, 32'd3},
      '{6'h04, T_BRANCH, C_BRANCH, 1'b0, 32'd3},
      '{6'h04, T_FETCH,  C_FETCH,  1'b0, 32'd4},
      '{6'h02, T_DECODE, C_DECODE, 1'b0, 32'd4},
      '{6'h02, T_JUMP,   C_JUMP,   1'b0, 32'd4},
      '{6'h02, T_FETCH,  C_FETCH,  1'b0, 32'd5},
      '{6'h08, T_DECODE, C_DECODE, 1'b0, 32'd5},
      '{6'h08, T_IEXEC,  C_IEXEC,  1'b0, 32'd5},
      '{6'h08, T_IWB,    C_IWB,    1'b0, 32'd5},
      '{6'h08, T_FETCH,  C_FETCH,  1'b0, 32'd6},
      '{6'h3f, T_DECODE, C_DECODE, 1'b0, 32'd6},
      '{6'h3f, T_FETCH,  C_FETCH,  1'b1, 32'd6},
      '{6'h00, T_DECODE, C_DECODE, 1'b0, 32'd6},
      '{6'h00, T_REXEC,  C_REXEC,  1'b0, 32'd6},
      '{6'h00, T_RWB,    C_RWB,    1'b0, 32'd6},
      '{6'h00, T_FETCH,  C_FETCH,  1'b0, 32'd7}
    };
    #1;
    for (int d = 0; d < 3; d++) check_all('{2'(d), T_RESET, C_NONE, 1'b0, 32'd0});
    #6;
    for (int d = 0; d < 3; d++) chk("held_in_reset", d, 32'(st[d]), 32'(T_RESET));
    reset = 1'b0;
    for (int i = 0; i < 30; i++) go(tbl[i].op, tbl[i].st, tbl[i].ctrl, tbl[i].ill, tbl[i].cnt);
    mcnt = 32'd7;
    for (int k = 0; k < 9; k++) r_type();
    chk("wrap_to_zero", 2, count[2], 32'd0);
    go(6'h23, T_DECODE, C_DECODE, 1'b0, mcnt);
    go(6'h23, T_MEMADR, C_MEMADR, 1'b0, mcnt);
    go(6'h23, T_MEMRD, C_MEMRD, 1'b0, mcnt);
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) check_all('{2'(d), T_RESET, C_NONE, 1'b0, 32'd0});
    @(negedge clock);
    reset  = 1'b0;
    halted = 1'b0;
    mcnt   = 0;
    go(6'h00, T_FETCH, C_FETCH, 1'b0, 32'd0);
    go(6'h08, T_DECODE, C_DECODE, 1'b0, 32'd0);
    go(6'h08, T_IEXEC, C_IEXEC, 1'b0, 32'd0);
    go(6'h08, T_IWB, C_IWB, 1'b0, 32'd0);
    go(6'h08, T_FETCH, C_FETCH, 1'b0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
